// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector load sequencer: state encoding and
// line/index width helpers used by the sequencer and its environment.
package mvm_pkg;

  typedef logic [2:0] mvm_seq_state_t;

  localparam mvm_seq_state_t ST_IDLE      = 3'd0;
  localparam mvm_seq_state_t ST_CLR       = 3'd1;
  localparam mvm_seq_state_t ST_REQ       = 3'd2;
  localparam mvm_seq_state_t ST_WAIT_DATA = 3'd3;
  localparam mvm_seq_state_t ST_COMPUTE   = 3'd4;
  localparam mvm_seq_state_t ST_DONE      = 3'd5;
  localparam mvm_seq_state_t ST_ERR       = 3'd6;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int LINE_W         = DEF_DEPTH * DEF_DATA_WIDTH;
  localparam int IDX_W          = $clog2(DEF_DEPTH + 2);

  function automatic int line_width(input int depth, input int data_width);
    return depth * data_width;
  endfunction

  // Index must reach DEPTH+1 (one past the B line) after a complete job.
  function automatic int idx_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/mvm_timeout_ctr.sv
// Per-wait cycle counter: cleared on state entry, counts while enabled and
// flags the last allowed cycle so the FSM can abort on that edge.
module mvm_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  // Expired during the TIMEOUT-th enabled cycle, so the abort lands exactly then.
  assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mvm_load_sequencer.sv
// Runs one matrix-vector job: clears the MAC, streams DEPTH A lines and one
// B line from memory into mat_vec_mult, then waits for its completion.
module mvm_load_sequencer
  import mvm_pkg::*;
#(
  parameter int                DATA_WIDTH = 8,
  parameter int                DEPTH      = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                TIMEOUT    = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [ADDR_W-1:0]                  mem_address,
  output logic                               mem_read,
  input  logic [line_width(DEPTH, DATA_WIDTH)-1:0] mem_readdata,
  input  logic                               mem_readdatavalid,
  input  logic                               mem_waitrequest,
  output logic                               mac_clr,
  output logic                               a_wren,
  output logic                               b_wren,
  output logic [line_width(DEPTH, DATA_WIDTH)-1:0] line_data,
  input  logic                               mac_done,
  output logic [idx_width(DEPTH)-1:0]        line_idx
);

  localparam int              LW       = line_width(DEPTH, DATA_WIDTH);
  localparam int              IW       = idx_width(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH);

  mvm_seq_state_t state_reg;
  mvm_seq_state_t state_next;
  logic [IW-1:0]  line_idx_reg;
  logic [LW-1:0]  line_data_reg;
  logic           a_wren_reg;
  logic           b_wren_reg;

  logic idle_like;
  logic job_start;
  logic capture;
  logic last_line;
  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expired;

  assign idle_like  = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                      (state_reg == ST_ERR);
  assign job_start  = idle_like && start;
  assign capture    = (state_reg == ST_WAIT_DATA) && mem_readdatavalid;
  assign last_line  = (line_idx_reg == LAST_IDX);
  assign tmo_enable = (state_reg == ST_REQ) || (state_reg == ST_WAIT_DATA);
  // Any state change restarts the window, which covers every entry to REQ/WAIT_DATA.
  assign tmo_clear  = (state_next != state_reg);

  mvm_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_next = ST_CLR;
      end
      ST_CLR: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        // Acceptance wins over the timeout on the final allowed cycle.
        if (!mem_waitrequest)  state_next = ST_WAIT_DATA;
        else if (tmo_expired)  state_next = ST_ERR;
      end
      ST_WAIT_DATA: begin
        if (mem_readdatavalid) state_next = last_line ? ST_COMPUTE : ST_REQ;
        else if (tmo_expired)  state_next = ST_ERR;
      end
      ST_COMPUTE: begin
        if (mac_done) state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_idx_reg <= '0;
    end else if (job_start) begin
      line_idx_reg <= '0;
    end else if (capture) begin
      line_idx_reg <= line_idx_reg + 1'b1;
    end
  end

  // Data and write strobes leave together one cycle after the memory beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_data_reg <= '0;
      a_wren_reg    <= 1'b0;
      b_wren_reg    <= 1'b0;
    end else begin
      if (capture) line_data_reg <= mem_readdata;
      a_wren_reg <= capture && !last_line;
      b_wren_reg <= capture && last_line;
    end
  end

  assign busy        = (state_reg == ST_CLR) || (state_reg == ST_REQ) ||
                       (state_reg == ST_WAIT_DATA) || (state_reg == ST_COMPUTE);
  assign done        = (state_reg == ST_DONE);
  assign err         = (state_reg == ST_ERR);
  assign mac_clr     = (state_reg == ST_CLR);
  assign mem_read    = (state_reg == ST_REQ);
  assign mem_address = BASE_ADDR + ADDR_W'(line_idx_reg);
  assign line_idx    = line_idx_reg;
  assign line_data   = line_data_reg;
  assign a_wren      = a_wren_reg;
  assign b_wren      = b_wren_reg;

endmodule

// File: tb/tb_mvm_load_sequencer.sv
// Bench for mvm_load_sequencer: random line images served by an Avalon-MM
// responder model, with a scoreboard of expected FIFO writes per job.
`timescale 1ns/1ps
module tb_mvm_load_sequencer;
  import mvm_pkg::*;

  localparam int              DEPTH = 8;
  localparam int              DW    = 8;
  localparam int              AW    = 32;
  localparam int              TMO   = 15;
  localparam int              LW    = LINE_W;
  localparam int              IW    = IDX_W;
  localparam logic [AW-1:0]   BASE  = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic [LW-1:0] mem_readdata = '0;
  logic          mem_readdatavalid = 1'b0;
  logic          mem_waitrequest = 1'b0;
  logic          mac_clr, a_wren, b_wren;
  logic [LW-1:0] line_data;
  logic          mac_done = 1'b0;
  logic [IW-1:0] line_idx;

  always #5 clk = ~clk;

  mvm_load_sequencer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE),
    .TIMEOUT    (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_waitrequest   (mem_waitrequest),
    .mac_clr           (mac_clr),
    .a_wren            (a_wren),
    .b_wren            (b_wren),
    .line_data         (line_data),
    .mac_done          (mac_done),
    .line_idx          (line_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image and responder configuration
  logic [LW-1:0] mem_img [0:DEPTH];
  int  wr_cfg   = 0;
  int  lat_cfg  = 1;
  int  hold_idx = -1;
  bit  spur_req  = 1'b0;
  bit  spur_idle = 1'b0;

  int  cyc = 0;
  int  data_due = -1;
  int  pend_idx = 0;
  int  wr_left = 0;
  int  rd_idx = 0;
  int  n_reads = 0;
  bit  outstanding = 1'b0;

  // Responder: drives the slave side at the falling edge, one decision per cycle.
  always @(negedge clk) begin
    cyc++;
    mem_readdatavalid = 1'b0;
    mem_readdata      = {$urandom(), $urandom()};
    if (!rst_n || mac_clr) begin
      data_due    = -1;
      outstanding = 1'b0;
      wr_left     = wr_cfg;
      rd_idx      = 0;
    end
    if (data_due == cyc) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = mem_img[pend_idx];
      outstanding       = 1'b0;
      data_due          = -1;
    end else if (spur_idle || (spur_req && mem_read)) begin
      mem_readdatavalid = 1'b1;
    end
    mem_waitrequest = 1'b0;
    if (mem_read) begin
      if ((hold_idx >= 0 && mem_address == BASE + AW'(hold_idx)) || wr_left > 0) begin
        mem_waitrequest = 1'b1;
        if (wr_left > 0) wr_left--;
      end else begin
        chk("one_outstanding", 64'(outstanding), 64'd0);
        chk("rd_addr", 64'(mem_address), 64'(BASE + AW'(rd_idx)));
        pend_idx    = (rd_idx <= DEPTH) ? rd_idx : DEPTH;
        rd_idx++;
        n_reads++;
        outstanding = 1'b1;
        data_due    = cyc + lat_cfg;
        wr_left     = wr_cfg;
      end
    end
  end

  // Scoreboard: lines must arrive in address order, A for 0..DEPTH-1, B for DEPTH.
  int mon_cyc = 0;
  int exp_idx = 0;
  int n_a = 0, n_b = 0, n_clr = 0, n_hold = 0;
  int clr_cyc = 0, b_cyc = 0;

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (mac_clr) begin
      n_clr++;
      clr_cyc = mon_cyc;
      exp_idx = 0;
    end
    if (hold_idx >= 0 && mem_read && mem_address == BASE + AW'(hold_idx)) n_hold++;
    if (a_wren || b_wren) begin
      chk("wren_kind", 64'({a_wren, b_wren}), (exp_idx < DEPTH) ? 64'd2 : 64'd1);
      chk("line_data", 64'(line_data), 64'(mem_img[(exp_idx > DEPTH) ? DEPTH : exp_idx]));
      if (a_wren) n_a++;
      if (b_wren) begin
        n_b++;
        b_cyc = mon_cyc;
      end
      exp_idx++;
    end
  end

  task automatic new_job(input int wr, input int lat);
    wr_cfg  = wr;
    lat_cfg = lat;
    for (int i = 0; i <= DEPTH; i++) mem_img[i] = {$urandom(), $urandom()};
    n_a = 0; n_b = 0; n_clr = 0; n_reads = 0; n_hold = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_b_or_err();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (n_b > 0 || err) return;
    end
    chk("wait_bound", 64'd0, 64'd1);
  endtask

  task automatic finish_job(input string name);
    wait_b_or_err();
    repeat (3) @(negedge clk);
    mac_done = 1'b1;
    @(negedge clk);
    mac_done = 1'b0;
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_err"}, 64'(err), 64'd0);
    chk({name, "_n_a"}, 64'(n_a), 64'(DEPTH));
    chk({name, "_n_b"}, 64'(n_b), 64'd1);
    chk({name, "_reads"}, 64'(n_reads), 64'(DEPTH + 1));
    chk({name, "_clr"}, 64'(n_clr), 64'd1);
    $display("[TB] job %s: reads=%0d a_wren=%0d b_wren=%0d done=%0b", name, n_reads, n_a, n_b, done);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_err"}, 64'(err), 64'd0);
    chk({name, "_read"}, 64'(mem_read), 64'd0);
    chk({name, "_clr"}, 64'(mac_clr), 64'd0);
    chk({name, "_wren"}, 64'({a_wren, b_wren}), 64'd0);
    chk({name, "_data"}, 64'(line_data), 64'd0);
    chk({name, "_idx"}, 64'(line_idx), 64'd0);
    chk({name, "_addr"}, 64'(mem_address), 64'(BASE));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Spurious data while idle
    @(negedge clk);
    spur_idle = 1'b1;
    repeat (4) @(negedge clk);
    spur_idle = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_idle_wren", 64'(n_a + n_b), 64'd0);
    chk("spur_idle_idx", 64'(line_idx), 64'd0);
    chk("spur_idle_data", 64'(line_data), 64'd0);
    $display("[TB] spurious idle: wren=%0d idx=%0d", n_a + n_b, line_idx);

    // Nominal: 2 wait cycles per read, latency 3
    new_job(2, 3);
    finish_job("nominal");
    repeat (5) @(negedge clk);
    chk("done_held", 64'(done), 64'd1);

    // Zero wait: three cycles per line after the clear cycle
    new_job(0, 2);
    finish_job("zerowait");
    chk("zerowait_cycles", 64'(b_cyc - clr_cyc), 64'(1 + (DEPTH + 1) * 3));

    // Spurious data while a request is stalled
    spur_req = 1'b1;
    new_job(2, 3);
    finish_job("spur_req");
    spur_req = 1'b0;

    // start while busy, then start coinciding with mac_done
    new_job(1, 4);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (line_idx == IW'(2) && busy && !mem_read && !mac_clr) break;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_b_or_err();
    repeat (2) @(negedge clk);
    mac_done = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    mac_done = 1'b0;
    start    = 1'b0;
    chk("busystart_done", 64'(done), 64'd1);
    chk("busystart_busy", 64'(busy), 64'd0);
    chk("busystart_reads", 64'(n_reads), 64'(DEPTH + 1));
    chk("busystart_n_a", 64'(n_a), 64'(DEPTH));
    repeat (3) @(negedge clk);
    chk("busystart_clr", 64'(n_clr), 64'd1);
    chk("busystart_done2", 64'(done), 64'd1);
    $display("[TB] job busystart: reads=%0d clr=%0d done=%0b", n_reads, n_clr, done);

    // Timeout: line 4 never accepted
    hold_idx = 4;
    new_job(1, 2);
    wait_b_or_err();
    @(negedge clk);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_done", 64'(done), 64'd0);
    chk("tmo_read", 64'(mem_read), 64'd0);
    chk("tmo_n_b", 64'(n_b), 64'd0);
    chk("tmo_n_a", 64'(n_a), 64'd4);
    chk("tmo_cycles", 64'(n_hold), 64'(TMO));
    $display("[TB] job timeout: stalled_cycles=%0d a_wren=%0d err=%0b", n_hold, n_a, err);
    hold_idx = -1;
    new_job(0, 1);
    finish_job("after_tmo");

    // Reset in the middle of line 5
    new_job(0, 3);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (line_idx == IW'(5)) break;
    end
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_n_a", 64'(n_a), 64'd5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_no_wren", 64'(n_a + n_b), 64'd5);
    $display("[TB] mid-job reset: a_wren=%0d before reset", n_a);
    new_job(1, 2);
    finish_job("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
